pc_fetch: RTL

Program-counter and instruction-fetch stage of the 16-bit RISC datapath. Holds the architectural PC, issues word fetches to instruction memory over a req/ack handshake, and presents each instruction with its PC and PC+2 to decode over a valid/ready handshake. Decode or execute can redirect the PC for branches and jumps. The block sits directly upstream of the PC+2 incrementer path and decode, and owns the only PC register in the design.

---
 rtl/riscp_pkg.sv | 18 +
 rtl/pc_incrementer.sv | 11 +
 rtl/pc_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscp_pkg.sv
// Shared constants and types for the 16-bit RISC datapath.
package riscp_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] PC_STEP       = 16'd2;
  localparam logic [ADDR_W-1:0] RESET_PC      = 16'h0000;
  localparam logic [ADDR_W-1:0] RESET_PC_NEXT = RESET_PC + PC_STEP;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential PC increment, wrapping modulo 2^ADDR_W.
module pc_incrementer
  import riscp_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus
);

  assign pc_plus = pc + PC_STEP;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch: req/ack to instruction memory,
// valid/ready to decode, with redirect taking priority in every state.
module pc_fetch
  import riscp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_next
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] target;

  // Instructions are halfword aligned, so the target's bit 0 is ignored.
  assign target = redirect_pc & ~ADDR_W'(1);

  pc_incrementer u_inc (
    .pc      (pc),
    .pc_plus (pc_plus)
  );

  // NOTE: every register here uses non-blocking assignment so all updates
  // in one edge see the pre-edge values of pc, state and the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= RESET_PC;
      if_pc_next <= RESET_PC_NEXT;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            pc        <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= pc;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            pc <= target;
            // Unacked request must complete at its original address first.
            if (imem_ack) imem_addr <= target;
            else          state     <= S_DRAIN;
          end else if (imem_ack) begin
            state      <= S_VALID;
            imem_req   <= 1'b0;
            if_valid   <= 1'b1;
            if_instr   <= imem_rdata;
            if_pc      <= pc;
            if_pc_next <= pc_plus;
          end
        end

        S_VALID: begin
          if (redirect_valid) begin
            state     <= S_FETCH;
            pc        <= target;
            if_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= target;
          end else if (if_ready) begin
            state     <= S_FETCH;
            pc        <= pc_plus;
            if_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= pc_plus;
          end
        end

        S_DRAIN: begin
          if (redirect_valid) pc <= target;
          if (imem_ack) begin
            state     <= S_FETCH;
            imem_addr <= redirect_valid ? target : pc;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
